// File: rtl/ram_burst_master.sv
// ram_burst_master: burst read/write initiator that owns the single-port ram,
// turning valid/ready bursts into registered ram cycles and a read-data stream.
module ram_burst_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              busy,
    output logic              ram_write_n,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  beats_left;
    logic [RD_LAT:0]   pipe;
    logic req_hs, wr_hs, last_beat, drain_done;
    assign req_ready  = state == IDLE && !rst;
    assign wr_ready   = state == WRITE && !rst;
    assign busy       = state != IDLE;
    assign req_hs     = req_valid && req_ready;
    assign wr_hs      = wr_valid && wr_ready;
    assign last_beat  = beats_left == '0;
    // only the oldest stage may still be occupied: that beat lands with done
    assign drain_done = state == DRAIN && pipe[RD_LAT-1:0] == '0;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_hs) state_nx = req_write ? WRITE : READ;
            WRITE:   if (wr_hs && last_beat) state_nx = IDLE;
            READ:    if (last_beat) state_nx = DRAIN;
            DRAIN:   if (drain_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_write_n <= 1'b1;
            ram_addr    <= '0;
            ram_data_in <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            done        <= 1'b0;
            pipe        <= '0;
            cur_addr    <= '0;
            beats_left  <= '0;
        end else begin
            ram_write_n <= !wr_hs;
            done        <= (wr_hs && last_beat) || drain_done;
            pipe        <= {pipe[RD_LAT-1:0], state == READ};
            rd_valid    <= pipe[RD_LAT];
            if (pipe[RD_LAT]) rd_data <= ram_data_out;
            if (req_hs) begin
                cur_addr   <= req_addr;
                beats_left <= req_len;
            end else if (wr_hs || state == READ) begin
                cur_addr   <= cur_addr + 1'b1;
                beats_left <= beats_left - 1'b1;
            end
            if (wr_hs) begin
                ram_addr    <= cur_addr;
                ram_data_in <= wr_data;
            end else if (state == READ) begin
                ram_addr <= cur_addr;
            end
        end
    end
endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: directed and random bursts against a ram model, with an
// expected-memory array and burst-level timing rules as the reference.
module tb_ram_burst_master;
    localparam int RD_LAT = 1;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [9:0]  req_addr;
    logic [3:0]  req_len;
    logic        wr_valid, wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid, done, busy, ram_write_n;
    logic [15:0] rd_data, ram_data_in, ram_data_out;
    logic [9:0]  ram_addr;
    logic        ram_init;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] mem [1024];
    logic [15:0] ref_mem [1024];
    logic [15:0] wdata [16];
    int          w_cyc[$], r_cyc[$], d_cyc[$];
    logic [9:0]  w_addr[$];
    logic [15:0] w_data[$], r_data[$];

    ram_burst_master dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .busy(busy),
        .ram_write_n(ram_write_n), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 947) ^ 16'h5a5a;
    endfunction

    // ram with one cycle of read latency
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        end else if (!ram_write_n) begin
            mem[ram_addr] <= ram_data_in;
        end
        ram_data_out <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (!ram_write_n) begin
            w_cyc.push_back(cyc);
            w_addr.push_back(ram_addr);
            w_data.push_back(ram_data_in);
        end
        if (rd_valid) begin
            r_cyc.push_back(cyc);
            r_data.push_back(rd_data);
        end
        if (done) d_cyc.push_back(cyc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        w_cyc.delete(); w_addr.delete(); w_data.delete();
        r_cyc.delete(); r_data.delete(); d_cyc.delete();
    endtask

    task automatic do_write(input logic [9:0] a, input logic [3:0] l, input int stall_beat,
                            input int stall_n, input bit gaps);
        int hs, n, n0, nb;
        logic [9:0] e;
        nb = int'(l) + 1;
        n0 = 0;
        clear_logs();
        check("wr_req_ready", req_ready, 1);
        req_valid = 1; req_write = 1; req_addr = a; req_len = l;
        step();
        hs = cyc;
        req_valid = 0; req_addr = 10'($urandom);
        check("wr_busy", busy, 1);
        for (int i = 0; i < nb; i++) begin
            n = (i == stall_beat) ? stall_n : (gaps ? int'($urandom_range(0, 2)) : 0);
            if (i == 0) n0 = n;
            wr_valid = 0;
            repeat (n) step();
            wr_valid = 1; wr_data = wdata[i];
            check("wr_ready", wr_ready, 1);
            step();
        end
        wr_valid = 0;
        check("wr_idle_after_done", req_ready, 1);
        @(negedge clk);
        #1;
        check("wr_count", w_addr.size(), nb);
        for (int i = 0; i < nb; i++) begin
            e = a + 10'(i);
            ref_mem[e] = wdata[i];
            if (i < w_addr.size()) begin
                check("wr_addr", w_addr[i], e);
                check("wr_data", w_data[i], wdata[i]);
            end
        end
        if (w_cyc.size() > 0) check("wr_first_lat", w_cyc[0] - hs, n0 + 1);
        if (stall_beat > 0 && w_cyc.size() > stall_beat)
            check("wr_stall_gap", w_cyc[stall_beat] - w_cyc[stall_beat-1], stall_n + 1);
        if (!gaps && stall_beat < 0 && w_cyc.size() == nb)
            check("wr_contig", w_cyc[nb-1] - w_cyc[0], nb - 1);
        check("wr_done_count", d_cyc.size(), 1);
        if (d_cyc.size() > 0 && w_cyc.size() > 0) check("wr_done_last", d_cyc[0], w_cyc[$]);
    endtask

    task automatic do_read(input logic [9:0] a, input logic [3:0] l, input int rst_at);
        int hs, nb, k;
        bit seen;
        nb = int'(l) + 1;
        clear_logs();
        check("rd_req_ready", req_ready, 1);
        req_valid = 1; req_write = 0; req_addr = a; req_len = l;
        wr_valid = 1; wr_data = 16'($urandom);
        step();
        hs = cyc;
        req_valid = 0;
        if (rst_at < 0) begin
            seen = 0;
            for (int t = 0; t < 40 && !seen; t++) begin
                step();
                seen = done;
            end
            check("rd_done_seen", seen, 1);
            wr_valid = 0;
            @(negedge clk);
            #1;
            check("rd_count", r_data.size(), nb);
            for (int i = 0; i < nb && i < r_data.size(); i++)
                check("rd_data", r_data[i], ref_mem[a + 10'(i)]);
            if (r_cyc.size() == nb) begin
                check("rd_first_lat", r_cyc[0] - hs, 1 + RD_LAT + 1);
                check("rd_contig", r_cyc[nb-1] - r_cyc[0], nb - 1);
            end
            check("rd_done_count", d_cyc.size(), 1);
            if (d_cyc.size() > 0 && r_cyc.size() > 0) check("rd_done_last", d_cyc[0], r_cyc[$]);
            check("rd_no_writes", w_addr.size(), 0);
        end else begin
            k = 0;
            for (int t = 0; t < 40 && k < rst_at; t++) begin
                step();
                if (rd_valid) k++;
            end
            check("rst_beats_before", k, rst_at);
            rst = 1;
            step();
            check("rst_rd_valid", rd_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_req_ready_low", req_ready, 0);
            rst = 0;
            #1;
            check("rst_req_ready_high", req_ready, 1);
            wr_valid = 0;
            repeat (4) step();
            @(negedge clk);
            #1;
            check("rst_no_more_beats", r_data.size(), rst_at);
            check("rst_no_done", d_cyc.size(), 0);
            check("rst_no_writes", w_addr.size(), 0);
        end
    endtask

    initial begin
        logic [9:0] a;
        logic [3:0] l;
        rst = 1; ram_init = 1;
        req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
        wr_valid = 0; wr_data = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        step();
        step();
        check("reset_write_n", ram_write_n, 1);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_req_ready", req_ready, 0);
        check("reset_wr_ready", wr_ready, 0);
        check("reset_ram_addr", ram_addr, 0);
        check("reset_rd_data", rd_data, 0);
        rst = 0; ram_init = 0;
        #1;
        check("post_reset_req_ready", req_ready, 1);
        for (int i = 0; i < 16; i++) wdata[i] = 16'(i);
        do_write(10'h000, 4'd15, -1, 0, 0);
        do_read(10'h000, 4'd15, -1);
        for (int i = 0; i < 16; i++) wdata[i] = 16'($urandom);
        do_write(10'h3FE, 4'd3, -1, 0, 0);
        do_read(10'h3FE, 4'd3, -1);
        for (int i = 0; i < 16; i++) wdata[i] = 16'($urandom);
        do_write(10'h100, 4'd7, 4, 3, 0);
        do_read(10'h100, 4'd7, -1);
        do_read(10'h000, 4'd15, 5);
        do_read(10'h3F8, 4'd15, -1);
        repeat (8) begin
            a = 10'($urandom);
            l = 4'($urandom);
            for (int i = 0; i < 16; i++) wdata[i] = 16'($urandom);
            do_write(a, l, -1, 0, 1);
            do_read(a + 10'($urandom_range(0, 6)), 4'($urandom), -1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
